// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Bundles the producer-side burst handshake and the FIFO write port that
//   fifo_wr_arbiter sits between.
//
//   Handshake: a beat on requester i transfers in the cycle where both
//   req_valid[i] and req_ready[i] are high. req_last[i] only has meaning
//   while req_valid[i] is high. Once raised, valid should stay up (with data
//   and last stable) until the beat is accepted, unless the producer wants
//   to pause its burst.
//
//   Signals
//     req_valid  NREQ             per-requester beat valid
//     req_last   NREQ             per-requester last beat of burst
//     req_data   NREQ*DATA_WIDTH  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//     req_ready  NREQ             per-requester beat accept (one-hot or zero)
//     fifo_full  1                FIFO full flag
//     fifo_wr    1                FIFO write enable
//     fifo_data  DATA_WIDTH       FIFO write data
//     grant_vld  1                a requester holds the grant
//     grant_id   ID_W             index of the granted requester
//
//   Modports
//     master : the environment (producers + FIFO) side
//     slave  : the arbiter side
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
    parameter int NREQ       = 4,
    parameter int ID_W       = 2,
    parameter int DATA_WIDTH = 8
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_last;
    logic [NREQ*DATA_WIDTH-1:0] req_data;
    logic [NREQ-1:0]            req_ready;
    logic                       fifo_full;
    logic                       fifo_wr;
    logic [DATA_WIDTH-1:0]      fifo_data;
    logic                       grant_vld;
    logic [ID_W-1:0]            grant_id;

    modport master (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_wr, fifo_data, grant_vld, grant_id
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_wr, fifo_data, grant_vld, grant_id
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter sharing one FIFO write port among NREQ burst
//   producers. One requester is granted at a time; its beats are forwarded
//   straight to the FIFO. The grant is released on an accepted last beat,
//   after MAX_BURST accepted beats, or after GAP_MAX idle cycles, and the
//   round-robin pointer then moves to the requester after the one released.
//
//   Ports
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     bus          fifo_wr_arbiter_if.slave (handshake + FIFO write port)
//     dbg_state_o  current FSM state (0 = IDLE, 1 = GRANT)
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NREQ       = 4,
    parameter int ID_W       = 2,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 8,
    parameter int GAP_MAX    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_wr_arbiter_if.slave    bus,
    output logic                dbg_state_o
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    state_e          state_q,     state_d;
    logic            grant_vld_q, grant_vld_d;
    logic [ID_W-1:0] grant_id_q,  grant_id_d;
    logic [ID_W-1:0] rr_ptr_q,    rr_ptr_d;
    logic [7:0]      beat_cnt_q,  beat_cnt_d;
    logic [7:0]      gap_cnt_q,   gap_cnt_d;

    // ---------------- round-robin search starting at rr_ptr ----------------
    logic            arb_found;
    logic [ID_W-1:0] arb_idx;
    logic [ID_W-1:0] cand;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = ID_W'((int'(rr_ptr_q) + i) % NREQ);
            if (!arb_found && bus.req_valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // ---------------- granted requester mux ----------------
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NREQ-1:0]       req_ready_c;
    logic                  in_grant;
    logic                  accept;

    assign in_grant = (state_q == S_GRANT);

    always_comb begin
        sel_valid   = 1'b0;
        sel_last    = 1'b0;
        sel_data    = '0;
        req_ready_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                sel_valid      = bus.req_valid[i];
                sel_last       = bus.req_last[i];
                sel_data       = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                // Ready does not depend on valid, only on grant and FIFO space.
                req_ready_c[i] = in_grant & ~bus.fifo_full;
            end
        end
    end

    // fifo_full gates the write directly, so the FIFO can never overflow.
    assign accept        = in_grant & sel_valid & ~bus.fifo_full;
    assign bus.fifo_wr   = accept;
    assign bus.fifo_data = sel_data;
    assign bus.req_ready = req_ready_c;
    assign bus.grant_vld = grant_vld_q;
    assign bus.grant_id  = grant_id_q;
    assign dbg_state_o   = (state_q == S_GRANT);

    // ---------------- next state ----------------
    logic       rel_now;
    logic [7:0] beat_inc;
    logic [7:0] gap_inc;

    always_comb begin
        state_d     = state_q;
        grant_vld_d = grant_vld_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        rel_now     = 1'b0;

        // Both counters saturate so they can never wrap past their limits.
        beat_inc = (beat_cnt_q >= 8'(MAX_BURST)) ? beat_cnt_q : beat_cnt_q + 8'd1;
        gap_inc  = (gap_cnt_q  >= 8'(GAP_MAX))   ? gap_cnt_q  : gap_cnt_q  + 8'd1;

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    state_d     = S_GRANT;
                    grant_vld_d = 1'b1;
                    grant_id_d  = arb_idx;
                    beat_cnt_d  = '0;
                    gap_cnt_d   = '0;
                end
            end
            S_GRANT: begin
                if (accept) begin
                    beat_cnt_d = beat_inc;
                    gap_cnt_d  = '0;
                    if (sel_last || (beat_inc == 8'(MAX_BURST))) begin
                        rel_now = 1'b1;
                    end
                end else if (!sel_valid) begin
                    gap_cnt_d = gap_inc;
                    if (gap_inc == 8'(GAP_MAX)) begin
                        rel_now = 1'b1;
                    end
                end
                // valid but FIFO full: hold everything, grant kept.

                if (rel_now) begin
                    state_d     = S_IDLE;
                    grant_vld_d = 1'b0;
                    rr_ptr_d    = (grant_id_q == ID_W'(NREQ-1)) ? '0 : grant_id_q + 1'b1;
                    beat_cnt_d  = '0;
                    gap_cnt_d   = '0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                grant_vld_d = 1'b0;
            end
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_vld_q <= 1'b0;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_vld_q <= grant_vld_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter: a cycle-by-cycle vector table for
//   single burst, round robin and gap timeout, then queue-driven producer
//   sequences for backpressure, forced release and reset mid-burst, with
//   FIFO writes checked against an expected-data queue.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int ID_W = 2;
    localparam int DW   = 8;

    logic clk;
    logic rst_n;
    logic dbg_state;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(
        .NREQ(NREQ), .ID_W(ID_W), .DATA_WIDTH(DW), .MAX_BURST(8), .GAP_MAX(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] exp_q[$];
    logic [8:0]    q_beat[NREQ][$];   // {last, data} per requester
    int            held_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
    endtask

    // Called at a negedge; returns at a negedge with reset released.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst_gvld",  32'(bus.grant_vld), 32'd0);
        chk("rst_gid",   32'(bus.grant_id),  32'd0);
        chk("rst_wr",    32'(bus.fifo_wr),   32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_state", 32'(dbg_state),     32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- producer driver ----------------
    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (q_beat[i].size() > 0) begin
                bus.req_valid[i]         = 1'b1;
                bus.req_last[i]          = q_beat[i][0][8];
                bus.req_data[i*DW +: DW] = q_beat[i][0][7:0];
            end else begin
                bus.req_valid[i]         = 1'b0;
                bus.req_last[i]          = 1'b0;
                bus.req_data[i*DW +: DW] = '0;
            end
        end
    endtask

    // Runs ncyc cycles; fifo_full is high for cycles full_lo..full_hi.
    task automatic run(input int ncyc, input int full_lo, input int full_hi);
        for (int c = 0; c < ncyc; c++) begin
            drive();
            bus.fifo_full = (c >= full_lo) && (c <= full_hi);
            #1;
            chk("no_wr_when_full", 32'(bus.fifo_wr & bus.fifo_full), 32'd0);
            chk("ready_onehot", 32'($countones(bus.req_ready) > 1), 32'd0);
            if (bus.fifo_full) begin
                chk("full_ready", 32'(bus.req_ready), 32'd0);
                if (bus.grant_vld) held_cnt++;
            end
            if (bus.fifo_wr) begin
                if (exp_q.size() == 0) chk("sb_extra_write", 32'(bus.fifo_data), 32'hffff_ffff);
                else                   chk("sb_data", 32'(bus.fifo_data), 32'(exp_q.pop_front()));
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) void'(q_beat[i].pop_front());
            end
            @(posedge clk);
            @(negedge clk);
        end
        clear_inputs();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          rst;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        full;
        logic        wr;
        logic [7:0]  wdata;
        logic [3:0]  ready;
        logic        gvld;
        logic [1:0]  gid;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, logic [3:0] valid, logic [3:0] last, logic [31:0] data,
                                logic full, logic wr, logic [7:0] wdata, logic [3:0] ready,
                                logic gvld, logic [1:0] gid);
        vec_t v;
        v.rst = rst; v.valid = valid; v.last = last; v.data = data; v.full = full;
        v.wr = wr; v.wdata = wdata; v.ready = ready; v.gvld = gvld; v.gid = gid;
        return v;
    endfunction

    initial begin
        //                rst valid    last     data          full wr wdata  ready    gvld gid
        // single burst on req0: 11, 22, 33(last)
        tbl.push_back(mk(1, 4'b0001, 4'b0000, 32'h0000_0011, 0, 0, 8'h00, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0000, 32'h0000_0011, 0, 1, 8'h11, 4'b0001, 1, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0000, 32'h0000_0022, 0, 1, 8'h22, 4'b0001, 1, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 32'h0000_0033, 0, 1, 8'h33, 4'b0001, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 8'h00, 4'b0000, 0, 0));
        // round robin, all valid, 1-beat bursts: 0,1,2,3,0
        tbl.push_back(mk(1, 4'b1111, 4'b1111, 32'hA3A2_A1A0, 0, 0, 8'h00, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hA3A2_A1A0, 0, 1, 8'hA0, 4'b0001, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hA3A2_A1A0, 0, 0, 8'h00, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hA3A2_A1A0, 0, 1, 8'hA1, 4'b0010, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hA3A2_A1A0, 0, 0, 8'h00, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hA3A2_A1A0, 0, 1, 8'hA2, 4'b0100, 1, 2));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hA3A2_A1A0, 0, 0, 8'h00, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hA3A2_A1A0, 0, 1, 8'hA3, 4'b1000, 1, 3));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hA3A2_A1A0, 0, 0, 8'h00, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hA3A2_A1A0, 0, 1, 8'hA0, 4'b0001, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 8'h00, 4'b0000, 0, 0));
        // gap timeout: req3 two beats then idle 4 cycles, then rr_ptr=0 -> req0 beats req3
        tbl.push_back(mk(1, 4'b1000, 4'b0000, 32'h3100_0000, 0, 0, 8'h00, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 32'h3100_0000, 0, 1, 8'h31, 4'b1000, 1, 3));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 32'h3200_0000, 0, 1, 8'h32, 4'b1000, 1, 3));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 8'h00, 4'b1000, 1, 3));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 8'h00, 4'b1000, 1, 3));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 8'h00, 4'b1000, 1, 3));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 8'h00, 4'b1000, 1, 3));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 8'h00, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b1001, 4'b1001, 32'h3300_0001, 0, 0, 8'h00, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b1001, 4'b1001, 32'h3300_0001, 0, 1, 8'h01, 4'b0001, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 8'h00, 4'b0000, 0, 0));

        // ---------------- start ----------------
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);

        for (int k = 0; k < tbl.size(); k++) begin
            if (tbl[k].rst) do_reset();
            bus.req_valid = tbl[k].valid;
            bus.req_last  = tbl[k].last;
            bus.req_data  = tbl[k].data;
            bus.fifo_full = tbl[k].full;
            #1;
            chk($sformatf("vec%0d_wr", k),    32'(bus.fifo_wr),   32'(tbl[k].wr));
            chk($sformatf("vec%0d_ready", k), 32'(bus.req_ready), 32'(tbl[k].ready));
            chk($sformatf("vec%0d_gvld", k),  32'(bus.grant_vld), 32'(tbl[k].gvld));
            if (tbl[k].wr)   chk($sformatf("vec%0d_wdata", k), 32'(bus.fifo_data), 32'(tbl[k].wdata));
            if (tbl[k].gvld) chk($sformatf("vec%0d_gid", k),   32'(bus.grant_id),  32'(tbl[k].gid));
            @(posedge clk);
            @(negedge clk);
        end
        clear_inputs();

        // ---------------- backpressure: full for 5 cycles mid-burst ----------------
        do_reset();
        held_cnt = 0;
        for (int b = 0; b < 6; b++) begin
            q_beat[0].push_back({(b == 5), 8'(8'h40 + b)});
            exp_q.push_back(8'(8'h40 + b));
        end
        run(20, 3, 7);
        chk("bp_held_cycles", 32'(held_cnt), 32'd5);
        chk("bp_sb_left", 32'(exp_q.size()), 32'd0);
        chk("bp_src_left", 32'(q_beat[0].size()), 32'd0);
        chk("bp_gvld_end", 32'(bus.grant_vld), 32'd0);

        // ---------------- forced release at MAX_BURST ----------------
        do_reset();
        for (int b = 0; b < 20; b++) q_beat[1].push_back({1'b0, 8'(8'h80 + b)});
        q_beat[2].push_back({1'b0, 8'hC0});
        q_beat[2].push_back({1'b1, 8'hC1});
        for (int b = 0; b < 8; b++)  exp_q.push_back(8'(8'h80 + b));
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hC1);
        for (int b = 8; b < 20; b++) exp_q.push_back(8'(8'h80 + b));
        run(45, 1000, 1000);
        chk("fr_sb_left", 32'(exp_q.size()), 32'd0);
        chk("fr_src1_left", 32'(q_beat[1].size()), 32'd0);
        chk("fr_src2_left", 32'(q_beat[2].size()), 32'd0);
        chk("fr_gvld_end", 32'(bus.grant_vld), 32'd0);

        // ---------------- reset mid-burst ----------------
        do_reset();
        for (int b = 0; b < 5; b++) q_beat[1].push_back({(b == 4), 8'(8'h50 + b)});
        exp_q.push_back(8'h50);
        exp_q.push_back(8'h51);
        run(3, 1000, 1000);
        chk("rm_pre_gvld", 32'(bus.grant_vld), 32'd1);
        drive();
        rst_n = 1'b0;
        #1;
        chk("rm_gvld_drop",  32'(bus.grant_vld), 32'd0);
        chk("rm_wr_drop",    32'(bus.fifo_wr),   32'd0);
        chk("rm_ready_drop", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q_beat[0].push_back({1'b1, 8'h05});
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h52);
        exp_q.push_back(8'h53);
        exp_q.push_back(8'h54);
        run(15, 1000, 1000);
        chk("rm_sb_left", 32'(exp_q.size()), 32'd0);
        chk("rm_src_left", 32'(q_beat[0].size() + q_beat[1].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
